// File: rtl/lii_pkg.sv
// Shared LII types and helpers: header ID width, default phy packing width,
// the {src, dst} header and zero-extension of kernel data onto the phy bus.
package lii_pkg;

  localparam int LII_ID_W       = 8;
  localparam int LII_PW_DEFAULT = 256;

  typedef struct packed {
    logic [LII_ID_W-1:0] src;
    logic [LII_ID_W-1:0] dst;
  } lii_hdr_t;

  // Clears every bit at or above position dw, so stale upper lanes never leak onto the phy.
  function automatic logic [LII_PW_DEFAULT-1:0] lii_pad(input logic [LII_PW_DEFAULT-1:0] data,
                                                        input int dw);
    logic [LII_PW_DEFAULT-1:0] mask;
    mask = '0;
    for (int i = 0; i < LII_PW_DEFAULT; i++) mask[i] = (i < dw);
    return data & mask;
  endfunction

endpackage

// File: rtl/lii_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty flags and an occupancy count.
// Pushes while full and pops while empty are ignored.
module lii_sync_fifo #(
  parameter int DW    = 192,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wr_data,
  input  logic                     pop,
  output logic [DW-1:0]            rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full    = (fill == (AW + 1)'(DEPTH));
  assign empty   = (fill == '0);
  assign wr_en   = push & ~full;
  assign rd_en   = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on their own.
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only readable after a write, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lii_stream_tx_port.sv
// Kernel-to-LII transmit endpoint: FIFO-buffered stream onto one phy channel plus kernel clock enable.
// Define LII_TX_STATS_EN to add saturating beat/stall counters (stat_beats, stat_stalls).
module lii_stream_tx_port
  import lii_pkg::*;
#(
  parameter int                  DW        = 192,
  parameter int                  PW        = 256,
  parameter int                  DEPTH     = 4,
  parameter int                  CE_MARGIN = 1,
  parameter logic [LII_ID_W-1:0] SRC_ID    = 8'h00,
  parameter logic [LII_ID_W-1:0] DST_ID    = 8'h00
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic [DW-1:0]          k_tdata,
  input  logic                   k_tvalid,
  output logic                   k_tready,
  output logic [PW-1:0]          lii_out_p0_tdata,
  output logic                   lii_out_p0_tvalid,
  input  logic                   lii_out_p0_tready,
  output logic [LII_ID_W-1:0]    lii_out_p0_src,
  output logic [LII_ID_W-1:0]    lii_out_p0_dst,
  output logic                   ce,
  output logic [$clog2(DEPTH):0] fill
`ifdef LII_TX_STATS_EN
  ,
  output logic [31:0]            stat_beats,
  output logic [31:0]            stat_stalls
`endif
);

  localparam int       FW       = $clog2(DEPTH) + 1;
  localparam int       CE_LIMIT = DEPTH - 1 - CE_MARGIN;
  localparam lii_hdr_t HDR      = '{src: SRC_ID, dst: DST_ID};

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [DW-1:0] head;

  // Ready and valid come from registered occupancy only; phy tready never reaches k_tready.
  assign k_tready          = ~full & ~arst;
  assign lii_out_p0_tvalid = ~empty;
  assign push              = k_tvalid & k_tready;
  assign pop               = lii_out_p0_tvalid & lii_out_p0_tready;

  lii_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (arst),
    .push    (push),
    .wr_data (k_tdata),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .fill    (fill)
  );

  assign lii_out_p0_tdata = PW'(lii_pad(LII_PW_DEFAULT'(head), DW));
  assign lii_out_p0_src   = HDR.src;
  assign lii_out_p0_dst   = HDR.dst;

  // Drops while CE_MARGIN slots remain so a beat already in flight in the kernel still fits.
  assign ce = ~arst & (fill <= FW'(CE_LIMIT));

`ifdef LII_TX_STATS_EN
  always_ff @(posedge aclk) begin
    if (arst) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (pop && stat_beats != '1) stat_beats <= stat_beats + 1'b1;
      if (lii_out_p0_tvalid && !lii_out_p0_tready && stat_stalls != '1)
        stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lii_stream_tx_port.sv
// Scoreboard bench for lii_stream_tx_port: accepted beats are queued, a negedge monitor checks every output.
module tb_lii_stream_tx_port;

  localparam int DW        = 192;
  localparam int PW        = 256;
  localparam int DEPTH     = 4;
  localparam int CE_MARGIN = 1;
  localparam int FW        = $clog2(DEPTH) + 1;

  logic          aclk;
  logic          arst;
  logic [DW-1:0] k_tdata;
  logic          k_tvalid;
  logic          k_tready;
  logic [PW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic [7:0]    src;
  logic [7:0]    dst;
  logic          ce;
  logic [FW-1:0] fill;
`ifdef LII_TX_STATS_EN
  logic [31:0]   stat_beats;
  logic [31:0]   stat_stalls;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb[$];
  int            m_fill = 0;
  bit            m_ok   = 0;

  lii_stream_tx_port #(
    .DW        (DW),
    .PW        (PW),
    .DEPTH     (DEPTH),
    .CE_MARGIN (CE_MARGIN),
    .SRC_ID    (8'h3C),
    .DST_ID    (8'hA5)
  ) dut (
    .aclk              (aclk),
    .arst              (arst),
    .k_tdata           (k_tdata),
    .k_tvalid          (k_tvalid),
    .k_tready          (k_tready),
    .lii_out_p0_tdata  (tdata),
    .lii_out_p0_tvalid (tvalid),
    .lii_out_p0_tready (tready),
    .lii_out_p0_src    (src),
    .lii_out_p0_dst    (dst),
    .ce                (ce),
    .fill              (fill)
`ifdef LII_TX_STATS_EN
    ,
    .stat_beats        (stat_beats),
    .stat_stalls       (stat_stalls)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Holds the beat until the DUT takes it, with a bounded wait.
  task automatic push_beat(input logic [DW-1:0] d);
    bit done;
    done     = 1'b0;
    k_tvalid = 1'b1;
    k_tdata  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge aclk);
      done = (k_tready === 1'b1);
      @(posedge aclk);
      #1;
    end
    k_tvalid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: beat %h not accepted within 50 cycles", d);
    end
  endtask

  // Monitor: compares current outputs with the model, then advances the model to the post-edge state.
  always @(negedge aclk) begin
    bit exp_push;
    bit exp_pop;
    if (m_ok) begin
      check("k_tready", PW'(k_tready), PW'((m_fill != DEPTH) && !arst));
      check("tvalid",   PW'(tvalid),   PW'(m_fill != 0));
      check("ce",       PW'(ce),       PW'(!arst && (m_fill <= DEPTH - 1 - CE_MARGIN)));
      check("fill",     PW'(fill),     PW'(m_fill));
      check("src",      PW'(src),      PW'(8'h3C));
      check("dst",      PW'(dst),      PW'(8'hA5));
      if (m_fill != 0 && sb.size() != 0) check("lii_tdata", tdata, PW'(sb[0]));
    end
    if (arst) begin
      sb.delete();
      m_fill = 0;
      m_ok   = 1'b1;
    end else if (m_ok) begin
      exp_push = k_tvalid && (m_fill != DEPTH);
      exp_pop  = (m_fill != 0) && tready;
      if (exp_pop && sb.size() != 0) void'(sb.pop_front());
      if (exp_push) sb.push_back(k_tdata);
      m_fill = m_fill + int'(exp_push) - int'(exp_pop);
    end
  end

  initial begin
    arst     = 1'b1;
    k_tvalid = 1'b0;
    k_tdata  = '0;
    tready   = 1'b1;

    // Reset held three cycles, then released.
    repeat (3) tick();
    arst = 1'b0;
    tick();

    // Back-to-back stream with the phy always ready.
    for (int n = 1; n <= 8; n++) push_beat(DW'(n));
    repeat (3) tick();

    // Backpressure: fill to DEPTH, try one refused beat, then drain.
    tready = 1'b0;
    for (int n = 1; n <= 4; n++) push_beat(DW'(n));
    k_tvalid = 1'b1;
    k_tdata  = DW'(99);
    repeat (2) tick();
    k_tvalid = 1'b0;
    repeat (2) tick();
    tready = 1'b1;
    repeat (6) tick();

    // Full with a simultaneous pop: push refused this cycle, accepted the next.
    tready = 1'b0;
    for (int n = 'h11; n <= 'h14; n++) push_beat(DW'(n));
    k_tvalid = 1'b1;
    k_tdata  = DW'('h15);
    tready   = 1'b1;
    tick();
    tready = 1'b0;
    tick();
    k_tvalid = 1'b0;

    // Mid-stream reset at fill 3; nothing stale may come out afterwards.
    tready = 1'b1;
    tick();
    tready = 1'b0;
    arst   = 1'b1;
    tick();
    arst   = 1'b0;
    tready = 1'b1;
    repeat (4) tick();

    // Ten pops with exactly five stalled cycles.
    tready = 1'b0;
    push_beat(DW'('hABC));
    repeat (5) tick();
    tready = 1'b1;
    for (int n = 2; n <= 10; n++) push_beat(DW'('hAB0 + n));
    repeat (4) tick();
`ifdef LII_TX_STATS_EN
    check("stat_beats",  PW'(stat_beats),  PW'(10));
    check("stat_stalls", PW'(stat_stalls), PW'(5));
`endif

    @(negedge aclk);
    check("sb_drained", PW'(sb.size()), PW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
